mod_mem_loader: RTL and testbench
=================================

MOD_MEM_LOADER -- requirements
Module: mod_mem_loader

Interface
REQ-001 The module SHALL have parameter NW_WIDTH, default 16, giving the width of the word-count input and the internal word counter.
REQ-002 The module SHALL have port clk, input, 1, the single system clock; all state SHALL update on its rising edge.
REQ-003 The module SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 The module SHALL have port start, input, 1, a single-cycle request to begin a load.
REQ-005 The module SHALL have port base, input, 32, the first word address, sampled on an accepted start.
REQ-006 The module SHALL have port nwords, input, NW_WIDTH, the number of 32-bit words to load, sampled on an accepted start.
REQ-007 The module SHALL have port bvalid, input, 1, meaning a byte is offered on bdata.
REQ-008 The module SHALL have port bdata, input, 8, the offered byte.
REQ-009 The module SHALL have port bready, output, 1, meaning the loader accepts a byte this cycle.
REQ-010 The module SHALL have port de, output, 1, the data-port enable to the memory bus.
REQ-011 The module SHALL have port drw, output, 1, the data-port write strobe (1 = write).
REQ-012 The module SHALL have port daddr, output, 32, the data-port byte address.
REQ-013 The module SHALL have port wdata, output, 32, the write data presented to the memory din.
REQ-014 The module SHALL have port busy, output, 1, high in every state other than IDLE.
REQ-015 The module SHALL have port done, output, 1, a one-cycle completion pulse.
REQ-016 The module SHALL have port csum, output, 32, the modulo-2^32 sum of all words written in the current or last load.

Function
REQ-017 The FSM SHALL have the states IDLE, COLLECT, WRITE and DONE.
REQ-018 In IDLE, start=1 SHALL latch base with bits [1:0] forced to 00, latch nwords, clear the word counter, byte counter and csum, and enter COLLECT; if nwords=0 it SHALL enter DONE instead.
REQ-019 start SHALL be ignored in every state other than IDLE.
REQ-020 bready SHALL be 1 only in COLLECT; a byte is accepted on an edge where bvalid and bready are both 1.
REQ-021 Byte assembly SHALL be big-endian: accepted bytes 0..3 of each word fill bits [31:24], [23:16], [15:8] and [7:0] in that order.
REQ-022 The 2-bit byte counter SHALL advance only on accepted bytes, and SHALL wrap from 3 to 0 on acceptance of the 4th byte, at which edge the FSM enters WRITE.
REQ-023 WRITE SHALL last exactly one cycle with de=1, drw=1, daddr=current address and wdata=the assembled word; the memory commits the word on the closing edge (no wait states).
REQ-024 The write cycle SHALL therefore occur in the cycle immediately after the edge that accepted the 4th byte.
REQ-025 On leaving WRITE, the module SHALL add 4 to the address, increment the word counter, and add wdata to csum (overflow discarded).
REQ-026 On leaving WRITE, the FSM SHALL enter DONE if the incremented word count equals nwords, otherwise COLLECT.
REQ-027 Address arithmetic SHALL be 32-bit and wrap from 32'hFFFFFFFC to 32'h00000000 without error.
REQ-028 DONE SHALL last one cycle with done=1 and then return to IDLE.
REQ-029 When de=0, drw, daddr and wdata SHALL all be 0 (driven, never high-impedance).
REQ-030 bvalid in states other than COLLECT SHALL have no effect; a bdata change without acceptance SHALL not alter state.
REQ-031 csum SHALL hold its value in IDLE until the next accepted start.

Reset
REQ-032 While rst=1 at a clock edge, the state SHALL become IDLE and all counters, address, assembly register and csum SHALL be cleared to 0.
REQ-033 All outputs after reset SHALL be 0 (bready, de, drw, daddr, wdata, busy, done, csum).
REQ-034 A reset asserted mid-load, including during WRITE, SHALL abort the load; no write cycle SHALL be issued for a partially assembled word after reset.

Verification
REQ-035 base=32'h10000003, nwords=2, bytes 11 22 33 44 55 66 77 88 -> writes 32'h11223344 @10000000 and 32'h55667788 @10000004, done pulse, csum=32'h6688AACC.
REQ-036 nwords=0 with start -> DONE on the next cycle, one-cycle done pulse, no de assertion, csum=0.
REQ-037 bvalid toggling with gaps of 0-5 idle cycles between bytes -> identical writes; exactly one de cycle per 4 accepted bytes, each immediately after the edge accepting the 4th byte.
REQ-038 base=32'hFFFFFFFC, nwords=2, bytes FF FF FF FF 00 00 00 02 -> writes @FFFFFFFC then @00000000, csum=32'h00000001.
REQ-039 rst pulsed after 2 bytes of word 1 -> all outputs 0, no write; a following load with base=0, nwords=1 succeeds cleanly.
REQ-040 start pulsed during COLLECT with different base -> ignored; the original load completes at the original addresses.

Source files
------------

// File: rtl/mod_mem_loader_if.sv
// Load-request, byte-stream and memory data-port signals of the memory loader.
// Master drives the request and byte stream; slave (the loader) drives bus and status.
interface mod_mem_loader_if #(
  parameter int NW_WIDTH = 16
);
  logic                start;
  logic [31:0]         base;
  logic [NW_WIDTH-1:0] nwords;
  logic                bvalid;
  logic [7:0]          bdata;
  logic                bready;
  logic                de;
  logic                drw;
  logic [31:0]         daddr;
  logic [31:0]         wdata;
  logic                busy;
  logic                done;
  logic [31:0]         csum;

  modport master (
    output start, base, nwords, bvalid, bdata,
    input  bready, de, drw, daddr, wdata, busy, done, csum
  );

  modport slave (
    input  start, base, nwords, bvalid, bdata,
    output bready, de, drw, daddr, wdata, busy, done, csum
  );
endinterface

// File: rtl/mod_mem_loader.sv
// Packs a big-endian byte stream into 32-bit words and writes them to consecutive addresses.
// Write issued the cycle after the 4th byte is accepted; bready drops outside COLLECT.
module mod_mem_loader #(
  parameter int NW_WIDTH = 16
) (
  input logic             clk,
  input logic             rst,
  mod_mem_loader_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_WRITE   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [31:0]         r_addr;
  logic [31:0]         r_word;
  logic [31:0]         r_csum;
  logic [NW_WIDTH-1:0] r_nwords;
  logic [NW_WIDTH-1:0] r_wcnt;
  logic [1:0]          r_bcnt;

  logic                w_start_acc;
  logic                w_byte_acc;
  logic                w_last_byte;
  logic                w_last_word;
  logic [NW_WIDTH-1:0] w_wcnt_inc;

  assign w_start_acc = (r_state == S_IDLE) && bus.start;
  assign w_byte_acc  = (r_state == S_COLLECT) && bus.bvalid;
  assign w_last_byte = w_byte_acc && (r_bcnt == 2'd3);
  assign w_wcnt_inc  = r_wcnt + {{(NW_WIDTH-1){1'b0}}, 1'b1};
  assign w_last_word = (w_wcnt_inc == r_nwords);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    bus.bready  = 1'b0;
    bus.de      = 1'b0;
    bus.drw     = 1'b0;
    bus.daddr   = 32'd0;
    bus.wdata   = 32'd0;
    bus.busy    = 1'b1;
    bus.done    = 1'b0;
    bus.csum    = r_csum;

    case (r_state)
      S_IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) begin
          w_state_nxt = (bus.nwords == '0) ? S_DONE : S_COLLECT;
        end
      end
      S_COLLECT: begin
        bus.bready = 1'b1;
        if (w_last_byte) begin
          w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        bus.de      = 1'b1;
        bus.drw     = 1'b1;
        bus.daddr   = r_addr;
        bus.wdata   = r_word;
        w_state_nxt = w_last_word ? S_DONE : S_COLLECT;
      end
      S_DONE: begin
        bus.done    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Start, byte and write updates occur in mutually exclusive states.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr   <= 32'd0;
      r_word   <= 32'd0;
      r_csum   <= 32'd0;
      r_nwords <= '0;
      r_wcnt   <= '0;
      r_bcnt   <= 2'd0;
    end else begin
      if (w_start_acc) begin
        r_addr   <= {bus.base[31:2], 2'b00};
        r_nwords <= bus.nwords;
        r_wcnt   <= '0;
        r_bcnt   <= 2'd0;
        r_csum   <= 32'd0;
        r_word   <= 32'd0;
      end
      if (w_byte_acc) begin
        r_bcnt <= r_bcnt + 2'd1;
        case (r_bcnt)
          2'd0:    r_word[31:24] <= bus.bdata;
          2'd1:    r_word[23:16] <= bus.bdata;
          2'd2:    r_word[15:8]  <= bus.bdata;
          default: r_word[7:0]   <= bus.bdata;
        endcase
      end
      if (r_state == S_WRITE) begin
        r_addr <= r_addr + 32'd4;
        r_wcnt <= w_wcnt_inc;
        r_csum <= r_csum + r_word;
      end
    end
  end

endmodule

// File: tb/tb_mod_mem_loader.sv
// Testbench for mod_mem_loader: table vectors, hand-written corner sequences and random loads
// compared against a word-list reference model built from the byte stream.
module tb_mod_mem_loader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mod_mem_loader_if #(.NW_WIDTH(16)) bus ();

  mod_mem_loader #(.NW_WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // ---------------- bus monitor ----------------
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          de_err   = 0;
  int          zero_err = 0;
  int          done_cnt = 0;
  int          byte_cnt = 0;
  logic        exp_de   = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      exp_de   = 1'b0;
      byte_cnt = 0;
    end else begin
      if (bus.de !== exp_de) de_err++;
      if (bus.de === 1'b1) begin
        if (bus.drw !== 1'b1) de_err++;
        wr_addr_q.push_back(bus.daddr);
        wr_data_q.push_back(bus.wdata);
      end else if (bus.drw !== 1'b0 || bus.daddr !== 32'd0 || bus.wdata !== 32'd0) begin
        zero_err++;
      end
      if (bus.done === 1'b1) done_cnt++;
      exp_de = 1'b0;
      if (bus.start && !bus.busy) begin
        wr_addr_q.delete();
        wr_data_q.delete();
        de_err   = 0;
        zero_err = 0;
        done_cnt = 0;
        byte_cnt = 0;
      end
      if (bus.bvalid && bus.bready) begin
        byte_cnt++;
        if (byte_cnt % 4 == 0) exp_de = 1'b1;
      end
    end
  end

  // ---------------- reference model ----------------
  logic [7:0]  stim_q[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [31:0] exp_csum;

  task automatic model(input logic [31:0] b, input int n);
    logic [31:0] d;
    exp_addr_q.delete();
    exp_data_q.delete();
    exp_csum = 32'd0;
    for (int i = 0; i < n; i++) begin
      d = {stim_q[4*i], stim_q[4*i+1], stim_q[4*i+2], stim_q[4*i+3]};
      exp_addr_q.push_back({b[31:2], 2'b00} + 32'(4 * i));
      exp_data_q.push_back(d);
      exp_csum = exp_csum + d;
    end
  endtask

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] b, input int n);
    bus.start  = 1'b1;
    bus.base   = b;
    bus.nwords = 16'(n);
    tick();
    bus.start  = 1'b0;
    bus.base   = $urandom;
    bus.nwords = 16'($urandom);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    logic acc;
    repeat (gap) begin
      bus.bvalid = 1'b0;
      bus.bdata  = 8'($urandom);
      tick();
    end
    bus.bvalid = 1'b1;
    bus.bdata  = b;
    acc = 1'b0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      acc = bus.bready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    bus.bvalid = 1'b0;
    bus.bdata  = 8'($urandom);
    check("byte_accepted", 32'(acc), 32'd1);
  endtask

  task automatic wait_done(output int lat);
    logic seen;
    seen = 1'b0;
    lat  = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      lat++;
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    check("done_seen", 32'(seen), 32'd1);
  endtask

  task automatic check_load(input int n);
    int m;
    repeat (2) tick();
    check("busy_after_done", 32'(bus.busy), 32'd0);
    check("done_pulses", 32'(done_cnt), 32'd1);
    check("de_timing_errors", 32'(de_err), 32'd0);
    check("idle_bus_nonzero", 32'(zero_err), 32'd0);
    check("write_count", 32'(wr_addr_q.size()), 32'(n));
    m = (wr_addr_q.size() < exp_addr_q.size()) ? wr_addr_q.size() : exp_addr_q.size();
    for (int i = 0; i < m; i++) begin
      check("write_addr", wr_addr_q[i], exp_addr_q[i]);
      check("write_data", wr_data_q[i], exp_data_q[i]);
    end
    check("csum", bus.csum, exp_csum);
  endtask

  task automatic run_load(input logic [31:0] b, input int n, input int maxgap);
    int lat;
    model(b, n);
    do_start(b, n);
    foreach (stim_q[i]) send_byte(stim_q[i], int'($urandom_range(0, maxgap)));
    wait_done(lat);
    if (n == 0) check("zero_len_done_latency", 32'(lat), 32'd1);
    check_load(n);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] base;
    int          nwords;
    logic [63:0] bytes;
    logic [31:0] exp_addr0;
    logic [31:0] exp_csum;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [31:0] rb;
    int          rn;
    logic [63:0] bv;
    int          lat;

    vecs[0] = '{32'h1000_0003, 2, 64'h1122_3344_5566_7788, 32'h1000_0000, 32'h6688_AACC};
    vecs[1] = '{32'h0000_0040, 0, 64'h0,                   32'h0,         32'h0};
    vecs[2] = '{32'hFFFF_FFFC, 2, 64'hFFFF_FFFF_0000_0002, 32'hFFFF_FFFC, 32'h0000_0001};
    vecs[3] = '{32'h0000_0102, 1, 64'hDEAD_BEEF_0000_0000, 32'h0000_0100, 32'hDEAD_BEEF};

    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.base   = 32'd0;
    bus.nwords = 16'd0;
    bus.bvalid = 1'b0;
    bus.bdata  = 8'd0;
    repeat (3) tick();
    rst = 1'b0;

    check("reset_ctrl", 32'({bus.bready, bus.de, bus.drw, bus.busy, bus.done}), 32'd0);
    check("reset_daddr", bus.daddr, 32'd0);
    check("reset_wdata", bus.wdata, 32'd0);
    check("reset_csum", bus.csum, 32'd0);

    // bytes offered while idle must be ignored
    bus.bvalid = 1'b1;
    bus.bdata  = 8'hA5;
    repeat (3) tick();
    check("idle_bvalid_busy", 32'(bus.busy), 32'd0);
    check("idle_bvalid_bready", 32'(bus.bready), 32'd0);
    bus.bvalid = 1'b0;

    for (int v = 0; v < 4; v++) begin
      stim_q.delete();
      bv = vecs[v].bytes;
      for (int i = 0; i < 4 * vecs[v].nwords; i++) stim_q.push_back(bv[63-8*i -: 8]);
      run_load(vecs[v].base, vecs[v].nwords, 5);
      check("table_csum", bus.csum, vecs[v].exp_csum);
      if (vecs[v].nwords > 0) check("table_addr0", wr_addr_q[0], vecs[v].exp_addr0);
    end

    // reset in the middle of a word aborts the load
    do_start(32'h0000_2000, 2);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_ctrl", 32'({bus.bready, bus.de, bus.drw, bus.busy, bus.done}), 32'd0);
    check("midrst_daddr", bus.daddr, 32'd0);
    check("midrst_wdata", bus.wdata, 32'd0);
    check("midrst_csum", bus.csum, 32'd0);
    repeat (3) tick();
    check("midrst_no_write", 32'(wr_addr_q.size()), 32'd0);
    stim_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_load(32'h0000_0000, 1, 2);

    // start during COLLECT with another base is ignored
    stim_q = '{8'hC0, 8'hFF, 8'hEE, 8'h01};
    model(32'h0000_8000, 1);
    do_start(32'h0000_8000, 1);
    send_byte(stim_q[0], 0);
    send_byte(stim_q[1], 2);
    bus.start  = 1'b1;
    bus.base   = 32'h5555_0000;
    bus.nwords = 16'd3;
    tick();
    bus.start  = 1'b0;
    send_byte(stim_q[2], 1);
    send_byte(stim_q[3], 0);
    wait_done(lat);
    check_load(1);

    // random loads with random inter-byte gaps
    for (int r = 0; r < 6; r++) begin
      rb = $urandom;
      rn = int'($urandom_range(1, 4));
      stim_q.delete();
      repeat (4 * rn) stim_q.push_back(8'($urandom_range(0, 255)));
      run_load(rb, rn, 5);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
